// File: rtl/btn_reset_exit_ctrl_if.sv
// Board-side signal bundle for btn_reset_exit_ctrl.
// The master drives the buttons, PLL lock and boot request; the slave is the controller.
interface btn_reset_exit_ctrl_if #(
   parameter int unsigned N_BTN = 7
);
   logic [N_BTN-1:0] btn_raw;
   logic             pll_locked;
   logic             boot_req;
   logic [N_BTN-1:0] btn_db;
   logic [N_BTN-1:0] btn_press;
   logic             sys_reset;
   logic             user_programn;
   logic             exit_pending;

   modport master (
      output btn_raw, pll_locked, boot_req,
      input  btn_db, btn_press, sys_reset, user_programn, exit_pending
   );

   modport slave (
      input  btn_raw, pll_locked, boot_req,
      output btn_db, btn_press, sys_reset, user_programn, exit_pending
   );
endinterface

// File: rtl/btn_reset_exit_ctrl.sv
// Button debounce, prolonged system reset and bootloader-exit sequencing for bootloader tops.
// The exit sequence holds off a guard interval before pulsing user_programn low.
module btn_reset_exit_ctrl #(
   parameter int unsigned      N_BTN           = 7,
   parameter logic [N_BTN-1:0] BTN_ACTIVE_LOW  = N_BTN'(7'b0000001),
   parameter int unsigned      RST_BTN_IDX     = 1,
   parameter int unsigned      EXIT_BTN_IDX    = 0,
   parameter int unsigned      DEBOUNCE_CYCLES = 480000,
   parameter int unsigned      PROLONG_CYCLES  = 32768,
   parameter int unsigned      LONG_CYCLES     = 96000000,
   parameter int unsigned      GUARD_CYCLES    = 4800000,
   parameter int unsigned      PROGN_CYCLES    = 48
) (
   input logic                    clk_48mhz,
   input logic                    reset,
   btn_reset_exit_ctrl_if.slave   bus
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned PR_W    = $clog2(PROLONG_CYCLES + 1);
   localparam int unsigned LG_W    = $clog2(LONG_CYCLES + 1);
   localparam int unsigned SEQ_MAX = (GUARD_CYCLES > PROGN_CYCLES) ? GUARD_CYCLES : PROGN_CYCLES;
   localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GUARD = 2'd1,
      S_PULSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] db;
   logic [N_BTN-1:0] press;
   logic [PR_W-1:0]  pr_cnt;
   logic             sys_rst;
   logic [LG_W-1:0]  lg_cnt;
   logic             boot_prev;
   logic             cause;
   logic             long_fire;
   logic             boot_rise;
   logic             trigger;

   state_t           state;
   state_t           state_next;
   logic [SEQ_W-1:0] seq_cnt;
   logic [SEQ_W-1:0] seq_cnt_next;
   logic             progn;
   logic             progn_next;
   logic             pending;
   logic             pending_next;

   // Two-flop synchroniser on the polarity-corrected buttons; reset value is "released".
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.btn_raw ^ BTN_ACTIVE_LOW;
         sync2 <= sync1;
      end
   end

   // Per-button debounce: btn_db follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   for (genvar g = 0; g < int'(N_BTN); g++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            db_bit;
      logic            press_bit;

      always_ff @(posedge clk_48mhz) begin
         if (reset) begin
            cnt       <= '0;
            db_bit    <= 1'b0;
            press_bit <= 1'b0;
         end else begin
            press_bit <= 1'b0;
            if (sync2[g] == db_bit) begin
               cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               cnt       <= '0;
               db_bit    <= sync2[g];
               press_bit <= sync2[g];
            end else begin
               cnt <= cnt + DB_W'(1);
            end
         end
      end

      assign db[g]    = db_bit;
      assign press[g] = press_bit;
   end

   // Prolonged reset; reset itself is one of the causes, so it also covers the synchronous reset.
   assign cause = reset | ~bus.pll_locked | db[RST_BTN_IDX];

   always_ff @(posedge clk_48mhz) begin
      if (cause) begin
         pr_cnt  <= '0;
         sys_rst <= 1'b1;
      end else if (pr_cnt != PR_W'(PROLONG_CYCLES)) begin
         pr_cnt  <= pr_cnt + PR_W'(1);
         sys_rst <= (pr_cnt + PR_W'(1)) != PR_W'(PROLONG_CYCLES);
      end
   end

   // Long-press hold counter saturates so long_fire strobes once per press.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         lg_cnt    <= '0;
         boot_prev <= 1'b1;
      end else begin
         boot_prev <= bus.boot_req;
         if (!db[EXIT_BTN_IDX]) begin
            lg_cnt <= '0;
         end else if (lg_cnt != LG_W'(LONG_CYCLES)) begin
            lg_cnt <= lg_cnt + LG_W'(1);
         end
      end
   end

   assign long_fire = db[EXIT_BTN_IDX] && (lg_cnt == LG_W'(LONG_CYCLES - 1));
   assign boot_rise = bus.boot_req & ~boot_prev;
   assign trigger   = long_fire | (boot_rise & ~sys_rst);

   // Exit sequencer state register.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state   <= S_IDLE;
         seq_cnt <= '0;
         progn   <= 1'b1;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         seq_cnt <= seq_cnt_next;
         progn   <= progn_next;
         pending <= pending_next;
      end
   end

   // Guard may be aborted by sys_reset; the programn pulse, once started, always completes.
   always_comb begin
      state_next   = state;
      seq_cnt_next = seq_cnt;
      progn_next   = progn;
      pending_next = pending;
      case (state)
         S_IDLE: begin
            if (trigger) begin
               state_next   = S_GUARD;
               seq_cnt_next = '0;
               pending_next = 1'b1;
            end
         end
         S_GUARD: begin
            if (sys_rst) begin
               state_next   = S_IDLE;
               seq_cnt_next = '0;
               pending_next = 1'b0;
            end else if (seq_cnt == SEQ_W'(GUARD_CYCLES - 1)) begin
               state_next   = S_PULSE;
               seq_cnt_next = '0;
               progn_next   = 1'b0;
            end else begin
               seq_cnt_next = seq_cnt + SEQ_W'(1);
            end
         end
         S_PULSE: begin
            if (seq_cnt == SEQ_W'(PROGN_CYCLES - 1)) begin
               state_next   = S_DONE;
               seq_cnt_next = '0;
               progn_next   = 1'b1;
            end else begin
               seq_cnt_next = seq_cnt + SEQ_W'(1);
            end
         end
         S_DONE: begin
            state_next = S_DONE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign bus.btn_db        = db;
   assign bus.btn_press     = press;
   assign bus.sys_reset     = sys_rst;
   assign bus.user_programn = progn;
   assign bus.exit_pending  = pending;

endmodule

// File: tb/tb_btn_reset_exit_ctrl.sv
// Scoreboard bench for btn_reset_exit_ctrl: a timestamp-based reference model predicts every
// registered output per edge; a monitor compares them one time unit after each rising edge.
module tb_btn_reset_exit_ctrl;

   localparam int unsigned NB    = 7;
   localparam logic [6:0]  MASK  = 7'b0000001;
   localparam int          RST_I = 1;
   localparam int          EXI_I = 0;
   localparam int          D     = 4;
   localparam int          P     = 8;
   localparam int          L     = 20;
   localparam int          G     = 5;
   localparam int          PG    = 3;
   localparam int          MAXE  = 8000;

   typedef struct packed {
      logic [6:0] db;
      logic [6:0] press;
      logic       sys;
      logic       progn;
      logic       pend;
   } exp_t;

   logic clk;
   logic reset;
   btn_reset_exit_ctrl_if #(.N_BTN(NB)) bus ();

   btn_reset_exit_ctrl #(
      .N_BTN(NB), .BTN_ACTIVE_LOW(MASK), .RST_BTN_IDX(RST_I), .EXIT_BTN_IDX(EXI_I),
      .DEBOUNCE_CYCLES(D), .PROLONG_CYCLES(P), .LONG_CYCLES(L),
      .GUARD_CYCLES(G), .PROGN_CYCLES(PG)
   ) dut (
      .clk_48mhz(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   exp_t expq[$];

   // Stimulus values for the next cycle
   logic [6:0] s_btn;
   logic       s_pll, s_boot, s_rst;

   // Reference model state (time-stamped, edge index e)
   int         e = 0;
   logic [6:0] ms1, ms2, mdb, mpress;
   logic [6:0] syn_hist [MAXE];
   int         last_flip [NB];
   int         last_cause;
   int         run_start;
   logic       mbprev;
   logic       m_sys;
   int         seq_t;

   task automatic model_edge();
      exp_t       x;
      logic [6:0] ndb, npress;
      logic       cause, fire, rise, trig, stable;
      e++;
      if (s_rst) begin
         ms1 = '0; ms2 = '0; mdb = '0; mpress = '0;
         for (int i = 0; i < int'(NB); i++) last_flip[i] = e;
         last_cause = e; m_sys = 1'b1; run_start = -1; mbprev = 1'b1; seq_t = -1;
      end else begin
         syn_hist[e] = ms2;
         ms2 = ms1;
         ms1 = s_btn ^ MASK;
         ndb = mdb; npress = '0;
         // A button flips once the last D synced samples all disagree with it.
         for (int i = 0; i < int'(NB); i++) begin
            stable = 1'b0;
            if (e - last_flip[i] >= D) begin
               stable = 1'b1;
               for (int j = 0; j < D; j++)
                  if (syn_hist[e - j][i] == mdb[i]) stable = 1'b0;
            end
            if (stable) begin
               ndb[i] = ~mdb[i];
               npress[i] = ndb[i];
               last_flip[i] = e;
            end
         end
         cause = ~s_pll | mdb[RST_I];
         if (cause) last_cause = e;
         if (mdb[EXI_I]) begin
            if (run_start < 0) run_start = e;
         end else begin
            run_start = -1;
         end
         fire = mdb[EXI_I] && (e - run_start == L - 1);
         rise = s_boot & ~mbprev;
         mbprev = s_boot;
         trig = fire | (rise & ~m_sys);
         if (seq_t < 0) begin
            if (trig) seq_t = e;
         end else if ((e - seq_t) >= 1 && (e - seq_t) <= G && m_sys) begin
            seq_t = -1;
         end
         mdb = ndb; mpress = npress;
         m_sys = (e - last_cause) < P;
      end
      x.db    = mdb;
      x.press = mpress;
      x.sys   = m_sys;
      x.pend  = (seq_t >= 0);
      x.progn = !(seq_t >= 0 && (e - seq_t) >= G && (e - seq_t) < G + PG);
      expq.push_back(x);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.btn_raw    = s_btn;
         bus.pll_locked = s_pll;
         bus.boot_req   = s_boot;
         reset          = s_rst;
         model_edge();
      end
   endtask

   function automatic logic [6:0] pressed(input logic [6:0] p);
      return MASK ^ p;
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, want);
      end
   endtask

   // Monitor: every registered output is presented each cycle
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (expq.size() > 0) begin
         x = expq.pop_front();
         check("btn_db",        bus.btn_db,                 x.db);
         check("btn_press",     bus.btn_press,              x.press);
         check("sys_reset",     7'(bus.sys_reset),          7'(x.sys));
         check("user_programn", 7'(bus.user_programn),      7'(x.progn));
         check("exit_pending",  7'(bus.exit_pending),       7'(x.pend));
      end
   end

   initial begin
      int dur;
      logic [6:0] pr;
      s_btn = MASK; s_pll = 1'b1; s_boot = 1'b0; s_rst = 1'b1;
      bus.btn_raw = MASK; bus.pll_locked = 1'b1; bus.boot_req = 1'b0; reset = 1'b1;

      // Reset with active-low button 0 idle high, then prolonged reset release
      cyc(3); s_rst = 1'b0; cyc(12);
      // Bounce on button 2, then a real press
      s_btn = pressed(7'b0000100); cyc(3);
      s_btn = MASK;                cyc(5);
      s_btn = pressed(7'b0000100); cyc(12);
      s_btn = MASK;                cyc(10);
      // PLL glitch and reset-button press restart the prolong
      s_pll = 1'b0; cyc(1); s_pll = 1'b1; cyc(12);
      s_btn = pressed(7'b0000010); cyc(8); s_btn = MASK; cyc(16);
      // boot_req edge during sys_reset is discarded, then a valid request
      s_pll = 1'b0; cyc(1); s_pll = 1'b1;
      s_boot = 1'b1; cyc(1); s_boot = 1'b0; cyc(12);
      s_boot = 1'b1; cyc(20); s_boot = 1'b0; cyc(4);
      s_boot = 1'b1; cyc(4);  s_boot = 1'b0; cyc(2);
      // Long press on exit button, then a second one in DONE
      s_rst = 1'b1; cyc(1); s_rst = 1'b0; cyc(10);
      s_btn = pressed(7'b0000001); cyc(40); s_btn = MASK; cyc(10);
      s_btn = pressed(7'b0000001); cyc(40); s_btn = MASK; cyc(6);
      // PLL loss during guard aborts the sequence
      s_rst = 1'b1; cyc(1); s_rst = 1'b0; cyc(10);
      s_boot = 1'b1; cyc(2); s_pll = 1'b0; cyc(1); s_pll = 1'b1; s_boot = 1'b0; cyc(15);
      // Reset on the second programn-low cycle
      s_rst = 1'b1; cyc(1); s_rst = 1'b0; cyc(10);
      s_boot = 1'b1; cyc(1); s_boot = 1'b0; cyc(G + 1);
      s_rst = 1'b1; cyc(1); s_rst = 1'b0; cyc(10);

      // Randomised segments with held levels, short glitches and occasional resets
      for (int seg = 0; seg < 140; seg++) begin
         s_rst  = ($urandom_range(0, 24) == 0);
         s_pll  = ($urandom_range(0, 14) != 0);
         s_boot = 1'($urandom_range(0, 1));
         pr     = 7'($urandom) & 7'($urandom) & 7'b1111101;
         if ($urandom_range(0, 7) == 0) pr[1] = 1'b1;
         if ($urandom_range(0, 3) == 0) pr[0] = 1'b1;
         s_btn  = pressed(pr);
         dur    = s_rst ? 1 : int'($urandom_range(1, 40));
         cyc(dur);
      end

      @(posedge clk); #2;
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_reset_exit_ctrl.md
Name: btn_reset_exit_ctrl

Overview:
Parametrised board-control block for the bootloader tops, sitting between the raw board buttons and PLL lock and the bootloader core. Per-button synchronisation and debounce, with polarity correction and press pulses. Generates a prolonged system reset from the reset input, loss of PLL lock, or a reset button. Sequences the bootloader-exit pulse on user_programn, triggered by a long press of an exit button or by a boot request from the bootloader.

Parameters:
N_BTN, 7, number of button inputs
BTN_ACTIVE_LOW, 7'b0000001, per-button mask; bit set = raw input is active low
RST_BTN_IDX, 1, button index that forces sys_reset
EXIT_BTN_IDX, 0, button index whose long press requests exit
DEBOUNCE_CYCLES, 480000, consecutive stable samples required (10 ms at 48 MHz); must be >= 1
PROLONG_CYCLES, 32768, sys_reset hold time after all reset causes clear; must be >= 1
LONG_CYCLES, 96000000, exit-button hold time for a long press (2 s)
GUARD_CYCLES, 4800000, delay from exit trigger to programn pulse, so USB can finish its handshake
PROGN_CYCLES, 48, user_programn low time

Ports:
clk_48mhz  in  1  sole clock
reset  in  1  synchronous, active-high reset
btn_raw  in  N_BTN  asynchronous board buttons
pll_locked  in  1  PLL lock; low forces sys_reset
boot_req  in  1  level from bootloader core; a rising edge requests exit
btn_db  out  N_BTN  debounced, polarity-corrected; 1 = pressed
btn_press  out  N_BTN  one-cycle pulse per debounced press
sys_reset  out  1  prolonged reset to bootloader core, active high
user_programn  out  1  active-low reconfigure request
exit_pending  out  1  high from exit trigger until reset

Behaviour:
- Reset values: btn_db=0, btn_press=0, sys_reset=1, user_programn=1, exit_pending=0, FSM=IDLE, all counters 0, sync flops=0 (logical released), boot_req_prev=1.
- Polarity: logical = btn_raw XOR BTN_ACTIVE_LOW. Two-flop synchroniser per bit.
- Debounce, per bit, with a counter of width clog2(DEBOUNCE_CYCLES+1):
  - If the synced value equals btn_db, the counter clears.
  - Otherwise the counter increments. On the cycle it would reach DEBOUNCE_CYCLES, btn_db takes the synced value and the counter clears.
  - Latency from raw edge to btn_db edge is exactly 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_db.
- btn_press[i]=1 for exactly the cycle in which btn_db[i] is first 1. A release produces no pulse.
- Prolong counter:
  - Cause = reset | ~pll_locked | btn_db[RST_BTN_IDX]. While cause is high: counter=0, sys_reset=1.
  - Otherwise the counter increments and saturates at PROLONG_CYCLES. sys_reset = (counter != PROLONG_CYCLES), registered.
  - sys_reset falls on the PROLONG_CYCLES-th edge after cause first samples low. Any cause re-asserting restarts the full prolong.
- Long press:
  - The hold counter increments while btn_db[EXIT_BTN_IDX]=1 and saturates at LONG_CYCLES. It clears on release.
  - long_fire is a single-cycle strobe when the counter reaches LONG_CYCLES: one strobe per press.
- boot_req edge: boot_req_rise = boot_req & ~boot_req_prev. It is valid only when sys_reset=0; edges during sys_reset are discarded, not queued.
- trigger = long_fire | (boot_req_rise & ~sys_reset).
- Exit FSM:
  - IDLE: on trigger go to GUARD, clear the counter, set exit_pending=1.
  - GUARD: count GUARD_CYCLES cycles, then go to PULSE. If sys_reset=1 during GUARD, abort to IDLE and clear exit_pending.
  - PULSE: user_programn=0 for exactly PROGN_CYCLES cycles, then go to DONE. PULSE is not aborted by sys_reset.
  - DONE: user_programn=1, exit_pending=1. Sticky; further triggers are ignored.
- Trigger during GUARD/PULSE/DONE is ignored. A simultaneous long_fire and boot_req_rise produce one sequence.
- The reset input at any point, including mid-PULSE, returns all state to reset values on the next edge.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
Use small overrides: DEBOUNCE=4, PROLONG=8, LONG=20, GUARD=5, PROGN=3.
- Bounce: btn_raw[2]=1 for 3 cycles, then 0 -> btn_db[2] stays 0. Then hold 1 for 12 cycles -> btn_db[2] rises exactly 6 cycles after the raw edge, and btn_press[2] is high for one cycle.
- Prolong: deassert reset with pll_locked=1 -> sys_reset falls on the 8th edge. Then drop pll_locked for 1 cycle -> sys_reset=1 on the next edge and falls 8 cycles after relock. A debounced press on btn[1] has the same effect.
- Long press: btn_raw[0]=0 (active low) for 40 cycles -> exit_pending rises 26 cycles after the raw edge, then user_programn=0 for exactly 3 cycles after the 5-cycle guard. FSM ends in DONE; a second long press produces no pulse.
- boot_req: pulse boot_req while sys_reset=1 -> nothing happens. Raise it again after sys_reset=0 -> guard of 5, then 3-cycle low pulse. Holding boot_req high retriggers nothing.
- Abort/reset: pll_locked drops during GUARD -> IDLE, exit_pending=0, no pulse. Assert reset on the 2nd PULSE cycle -> user_programn=1 and exit_pending=0 on the next edge.
- Polarity: btn_raw[0]=1 at idle -> btn_db[0]=0, with no press pulse after reset.
